// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_queue
//  Description : Transmit byte queue in front of the memory-mapped UART.
//                Producers push bytes into a circular FIFO; a sequencer FSM
//                launches one UART frame per byte by writing the TX register,
//                then waits for the UART TX-busy bit to rise and fall before
//                launching the next byte.
//  Ports       : clk, rst          - clock (rising edge), async active-high reset
//                pushValid/pushData/pushReady - producer push handshake
//                count             - bytes currently queued (0..DEPTH)
//                uartWrtEn/uartAddr/uartTxData - UART bus write port
//                uartReadReg       - UART status read-back, bit 1 = TX busy
//                idle              - FSM idle and queue empty
//                errTimeout        - sticky busy-timeout flag
//                flush             - (UART_TXQ_FLUSH_EN only) empties the queue
//  Config      : `define UART_TXQ_FLUSH_EN to add the synchronous flush input.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pushValid,
    input  logic [7:0]        pushData,
    output logic              pushReady,
    output logic [ADDR_W:0]   count,
    output logic              uartWrtEn,
    output logic              uartAddr,
    output logic [31:0]       uartTxData,
    input  logic [31:0]       uartReadReg,
    output logic              idle,
`ifdef UART_TXQ_FLUSH_EN
    input  logic              flush,
`endif
    output logic              errTimeout
);

    localparam int              TMO_W      = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] c_tmoLast = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0] c_full     = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wrPtr;
    logic [ADDR_W-1:0]   r_rdPtr;
    logic [ADDR_W:0]     r_count;
    logic [TMO_W-1:0]    r_tmoCnt;
    logic                r_wrtEn;
    logic [31:0]         r_txData;
    logic                r_errTimeout;
    logic                w_busy;
    logic                w_flush;
    logic                w_push;
    logic                w_pop;
    logic                w_tmoHit;
    logic                w_unused;

`ifdef UART_TXQ_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Only the TX-busy bit of the status word matters here.
    assign w_busy   = uartReadReg[1];
    assign w_unused = ^{uartReadReg[31:2], uartReadReg[0]};

    assign pushReady = (r_count != c_full);
    // Flush wins over a simultaneous push: the offered byte is discarded.
    assign w_push    = pushValid && pushReady && !w_flush;
    // LAUNCH is only entered with a non-empty queue and nothing else pops,
    // so the head entry is guaranteed valid here.
    assign w_pop     = (r_state == S_LAUNCH);

    assign count      = r_count;
    assign uartWrtEn  = r_wrtEn;
    assign uartAddr   = 1'b0;
    assign uartTxData = r_txData;
    assign errTimeout = r_errTimeout;
    assign idle       = (r_state == S_IDLE) && (r_count == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_tmoHit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !w_busy) begin
                    w_nextState = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_nextState = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (w_busy) begin
                    w_nextState = S_WAIT_DONE;
                end else if (r_tmoCnt == c_tmoLast) begin
                    // The launched byte is abandoned, not retried.
                    w_tmoHit    = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!w_busy) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (w_flush) begin
            w_nextState = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State, pointers, counters and registered UART outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_tmoCnt     <= '0;
            r_wrtEn      <= 1'b0;
            r_txData     <= '0;
            r_errTimeout <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + ADDR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + (ADDR_W + 1)'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - (ADDR_W + 1)'(1);
                end
            end

            // Saturating wait counter, restarted for every launch.
            if (r_state == S_LAUNCH) begin
                r_tmoCnt <= '0;
            end else if ((r_state == S_WAIT_BUSY) && !w_busy && (r_tmoCnt != c_tmoLast)) begin
                r_tmoCnt <= r_tmoCnt + TMO_W'(1);
            end

            if (w_tmoHit) begin
                r_errTimeout <= 1'b1;
            end

            // Outputs are registered so they are asserted exactly while the
            // FSM sits in LAUNCH; the head byte is stable until that pop.
            if (w_nextState == S_LAUNCH) begin
                r_wrtEn  <= 1'b1;
                r_txData <= {r_mem[r_rdPtr], 23'b0, 1'b1};
            end else begin
                r_wrtEn  <= 1'b0;
                r_txData <= '0;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_queue
//  Description : Self-checking bench for uart_tx_queue. A small UART model
//                raises TX busy for a fixed frame length after each launch
//                write; a scoreboard of queued bytes is checked against every
//                launch seen on the UART bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 64;
    localparam int FRAME = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pushValid = 1'b0;
    logic [7:0]    pushData = 8'h00;
    logic          pushReady;
    logic [AW:0]   count;
    logic          uartWrtEn;
    logic          uartAddr;
    logic [31:0]   uartTxData;
    logic [31:0]   uartReadReg;
    logic          idle;
    logic          errTimeout;
`ifdef UART_TXQ_FLUSH_EN
    logic          flush = 1'b0;
`endif

    int nCompared = 0;
    int nMismatch = 0;

    logic [7:0] sb[$];

    // UART model controls
    logic busyForce = 1'b0;
    logic noBusy    = 1'b0;
    int   frameCnt  = 0;
    logic busy;

    uart_tx_queue #(
        .DEPTH        (DEPTH),
        .ADDR_W       (AW),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pushValid   (pushValid),
        .pushData    (pushData),
        .pushReady   (pushReady),
        .count       (count),
        .uartWrtEn   (uartWrtEn),
        .uartAddr    (uartAddr),
        .uartTxData  (uartTxData),
        .uartReadReg (uartReadReg),
        .idle        (idle),
`ifdef UART_TXQ_FLUSH_EN
        .flush       (flush),
`endif
        .errTimeout  (errTimeout)
    );

    always #5 clk = ~clk;

    // UART model: busy for FRAME cycles after each launch write.
    always @(posedge clk) begin
        if (uartWrtEn && !noBusy) begin
            frameCnt <= FRAME;
        end else if (frameCnt != 0) begin
            frameCnt <= frameCnt - 1;
        end
    end
    assign busy        = busyForce || (frameCnt != 0);
    // Unrelated status bits are held high so only bit 1 should matter.
    assign uartReadReg = {30'h3FFF_FFFF, busy, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch monitor / scoreboard pop.
    always @(negedge clk) begin
        if (!rst && uartWrtEn) begin
            check("launch_busy_clear", {31'b0, busy}, 32'h0);
            check("uart_addr", {31'b0, uartAddr}, 32'h0);
            if (sb.size() == 0) begin
                check("launch_unexpected", 32'h1, 32'h0);
            end else begin
                logic [7:0] b;
                b = sb.pop_front();
                check("launch_data", uartTxData, {b, 23'b0, 1'b1});
            end
        end
    end

    task automatic pushByte(input logic [7:0] b);
        @(negedge clk);
        pushValid = 1'b1;
        pushData  = b;
        if (pushReady) sb.push_back(b);
    endtask

    task automatic pushWait(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        pushValid = 1'b0;
        while (!pushReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("push_wait_timeout", 32'h1, 32'h0);
        pushValid = 1'b1;
        pushData  = b;
        sb.push_back(b);
    endtask

    task automatic endPush();
        @(negedge clk);
        pushValid = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while (!(idle && sb.size() == 0 && frameCnt == 0) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxCycles) check("drain_timeout", 32'h1, 32'h0);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_wrtEn"},  {31'b0, uartWrtEn}, 32'h0);
        check({tag, "_txData"}, uartTxData, 32'h0);
        check({tag, "_count"},  {27'b0, count}, 32'h0);
        check({tag, "_idle"},   {31'b0, idle}, 32'h1);
        check({tag, "_ready"},  {31'b0, pushReady}, 32'h1);
        check({tag, "_err"},    {31'b0, errTimeout}, 32'h0);
    endtask

    initial begin
        int n;
        // ---- reset state ----
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(negedge clk);

        // ---- single byte latency and data ----
        pushByte(8'hA5);
        endPush();
        check("single_count1", {27'b0, count}, 32'd1);
        check("single_noWrtYet", {31'b0, uartWrtEn}, 32'h0);
        @(negedge clk);
        check("single_wrtEn", {31'b0, uartWrtEn}, 32'h1);
        check("single_txData", uartTxData, 32'hA500_0001);
        @(negedge clk);
        check("single_wrtEnLow", {31'b0, uartWrtEn}, 32'h0);
        check("single_count0", {27'b0, count}, 32'd0);
        check("single_txData0", uartTxData, 32'h0);
        check("single_notIdleWhileBusy", {31'b0, idle}, 32'h0);
        waitDrain(100);
        check("single_idle", {31'b0, idle}, 32'h1);

        // ---- fill with busy held ----
        @(negedge clk);
        busyForce = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("fill_ready", {31'b0, pushReady}, (i < DEPTH) ? 32'h1 : 32'h0);
            pushValid = 1'b1;
            pushData  = 8'(i);
            if (i < DEPTH) sb.push_back(8'(i));
        end
        endPush();
        check("fill_count", {27'b0, count}, 32'd16);
        check("fill_readyLow", {31'b0, pushReady}, 32'h0);
        busyForce = 1'b0;
        waitDrain(500);
        check("fill_drained", {27'b0, count}, 32'd0);

        // ---- simultaneous push / pop ----
        @(negedge clk);
        busyForce = 1'b1;
        pushByte(8'h11);
        pushByte(8'h22);
        pushByte(8'h33);
        endPush();
        check("pp_count3", {27'b0, count}, 32'd3);
        busyForce = 1'b0;
        @(negedge clk);
        check("pp_launch", {31'b0, uartWrtEn}, 32'h1);
        pushValid = 1'b1;
        pushData  = 8'h77;
        sb.push_back(8'h77);
        @(negedge clk);
        pushValid = 1'b0;
        check("pp_countSame", {27'b0, count}, 32'd3);
        waitDrain(300);

        // ---- 40 bytes across pointer wrap ----
        for (int i = 0; i < 40; i++) begin
            pushWait(8'((i * 7 + 3) & 8'hFF));
        end
        endPush();
        waitDrain(2000);
        check("wrap_count0", {27'b0, count}, 32'd0);

        // ---- busy timeout ----
        noBusy = 1'b1;
        pushByte(8'h5A);
        pushByte(8'h3C);
        endPush();
        n = 0;
        while (!uartWrtEn && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tmo_firstLaunch", {31'b0, uartWrtEn}, 32'h1);
        repeat (TMO) @(negedge clk);
        check("tmo_errNotYet", {31'b0, errTimeout}, 32'h0);
        @(negedge clk);
        check("tmo_errSet", {31'b0, errTimeout}, 32'h1);
        @(negedge clk);
        check("tmo_nextLaunch", {31'b0, uartWrtEn}, 32'h1);
        check("tmo_nextData", uartTxData, 32'h3C00_0001);
        waitDrain(TMO + 20);
        check("tmo_sticky", {31'b0, errTimeout}, 32'h1);
        noBusy = 1'b0;

        // ---- asynchronous reset mid-frame ----
        pushByte(8'hC1);
        pushByte(8'hC2);
        pushByte(8'hC3);
        endPush();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkResetState("midReset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        waitDrain(100);

`ifdef UART_TXQ_FLUSH_EN
        // ---- flush ----
        busyForce = 1'b1;
        for (int i = 0; i < 5; i++) pushByte(8'(8'hE0 + i));
        endPush();
        check("flush_count5", {27'b0, count}, 32'd5);
        flush     = 1'b1;
        pushValid = 1'b1;
        pushData  = 8'hEE;
        @(negedge clk);
        flush     = 1'b0;
        pushValid = 1'b0;
        sb.delete();
        check("flush_count0", {27'b0, count}, 32'd0);
        check("flush_idle", {31'b0, idle}, 32'h1);
        busyForce = 1'b0;
        repeat (20) @(negedge clk);
        check("flush_stillEmpty", {27'b0, count}, 32'd0);
`endif

        @(negedge clk);
        check("final_sbEmpty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
